// File: rtl/dp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : dp_pkg                                                       |
// | Shared types and width/arithmetic helpers for the dot-product family   |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package dp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  // Valid tag carried alongside each beat through the multiply-add chain.
  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_res_t;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // A full N-term sum of IN_WIDTH x IN_WIDTH products fits exactly.
  function automatic int psum_w(input int n, input int in_w);
    return 2 * in_w + clog2(n);
  endfunction

  function automatic int acc_w(input int n, input int in_w, input int guard);
    return psum_w(n, in_w) + guard;
  endfunction

  // Signed add checked against a w-bit result range (w <= 62). When sat is
  // set the result clamps to the range limits; otherwise the caller keeps
  // the low w bits, which is a two's-complement wrap.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int w, input logic sat);
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    sat_res_t r;
    s = a + b;
    mx = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn = -mx - 64'sd1;
    r.ovf = 1'b0;
    r.val = s;
    if (s > mx) begin
      r.ovf = 1'b1;
      if (sat) r.val = mx;
    end else if (s < mn) begin
      r.ovf = 1'b1;
      if (sat) r.val = mn;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_mac_tap.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : systolic_mac_tap                                             |
// | One chain tap: input skew, pipelined signed multiply, add to the       |
// | incoming partial sum. The output register is the last multiply stage.  |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module systolic_mac_tap #(
  parameter int IN_WIDTH        = 10,
  parameter int SKEW            = 0,
  parameter int MULT_PIPE_DEPTH = 1,
  parameter int ADD_EN          = 1,
  parameter int SUM_W           = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] a,
  input  logic signed [IN_WIDTH-1:0] b,
  input  logic signed [SUM_W-1:0]    sum_in,
  output logic signed [SUM_W-1:0]    sum_out
);

  logic signed [IN_WIDTH-1:0]   w_a_sk;
  logic signed [IN_WIDTH-1:0]   w_b_sk;
  logic signed [2*IN_WIDTH-1:0] w_prod;
  logic signed [2*IN_WIDTH-1:0] w_prod_d;
  logic signed [SUM_W-1:0]      w_addend;

  generate
    if (SKEW > 0) begin : g_skew
      logic signed [IN_WIDTH-1:0] r_a_sr [SKEW];
      logic signed [IN_WIDTH-1:0] r_b_sr [SKEW];
      // Delay this tap's operands so they meet the partial sum of tap SKEW-1.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < SKEW; k++) begin
            r_a_sr[k] <= '0;
            r_b_sr[k] <= '0;
          end
        end else if (en) begin
          r_a_sr[0] <= a;
          r_b_sr[0] <= b;
          for (int k = 1; k < SKEW; k++) begin
            r_a_sr[k] <= r_a_sr[k-1];
            r_b_sr[k] <= r_b_sr[k-1];
          end
        end
      end
      assign w_a_sk = r_a_sr[SKEW-1];
      assign w_b_sk = r_b_sr[SKEW-1];
    end else begin : g_noskew
      assign w_a_sk = a;
      assign w_b_sk = b;
    end
  endgenerate

  assign w_prod = w_a_sk * w_b_sk;

  generate
    if (MULT_PIPE_DEPTH > 1) begin : g_mpipe
      logic signed [2*IN_WIDTH-1:0] r_prod_sr [MULT_PIPE_DEPTH-1];
      // Extra product stages ahead of the add register.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < MULT_PIPE_DEPTH - 1; k++) r_prod_sr[k] <= '0;
        end else if (en) begin
          r_prod_sr[0] <= w_prod;
          for (int k = 1; k < MULT_PIPE_DEPTH - 1; k++) r_prod_sr[k] <= r_prod_sr[k-1];
        end
      end
      assign w_prod_d = r_prod_sr[MULT_PIPE_DEPTH-2];
    end else begin : g_nompipe
      assign w_prod_d = w_prod;
    end
  endgenerate

  generate
    if (ADD_EN != 0) begin : g_add
      assign w_addend = sum_in;
    end else begin : g_noadd
      logic unused_sum_in;
      assign w_addend      = '0;
      assign unused_sum_in = ^sum_in;
    end
  endgenerate

  // Sign-extended product plus the upstream partial sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sum_out <= '0;
    else if (en) sum_out <= w_addend + SUM_W'(w_prod_d);
  end

endmodule
`default_nettype wire

// File: rtl/dot_product_systolic_acc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dot_product_systolic_acc                                     |
// | N-element signed systolic dot product with optional multi-chunk        |
// | accumulation, saturating or wrapping on accumulator overflow.          |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module dot_product_systolic_acc
  import dp_pkg::*;
#(
  parameter int N               = 16,
  parameter int IN_WIDTH        = 10,
  parameter int INPUT_REG_DEPTH = 1,
  parameter int MULT_PIPE_DEPTH = 1,
  parameter int ACCUMULATE      = 1,
  parameter int ACC_GUARD       = 8,
  parameter int SATURATE        = 1,
  localparam int PSUM_W = psum_w(N, IN_WIDTH),
  localparam int ACC_W  = acc_w(N, IN_WIDTH, ACC_GUARD)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    inReady,
  input  logic                    inFirst,
  input  logic                    inLast,
  input  logic [N*IN_WIDTH-1:0]   A,
  input  logic [N*IN_WIDTH-1:0]   B,
  output logic                    earlyOutReady,
  output logic                    outReady,
  output logic signed [ACC_W-1:0] DP,
  output logic                    overflow
);

  localparam int LAT_P = INPUT_REG_DEPTH + MULT_PIPE_DEPTH + N - 1;

  logic [N*IN_WIDTH-1:0]   r_a_in [INPUT_REG_DEPTH];
  logic [N*IN_WIDTH-1:0]   r_b_in [INPUT_REG_DEPTH];
  logic [N*IN_WIDTH-1:0]   w_a_in;
  logic [N*IN_WIDTH-1:0]   w_b_in;
  logic signed [PSUM_W-1:0] w_psum [N];
  tag_t                    r_tag [LAT_P];
  tag_t                    w_tag_in;
  tag_t                    w_tag_end;
  acc_state_t              r_state;
  acc_state_t              w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic                    r_ovf;
  logic                    w_ovf_nxt;
  logic                    w_emit;
  sat_res_t                w_sa;
  logic                    w_unused_hi;

  // Input register stages ahead of tap 0; validity is tracked by the tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < INPUT_REG_DEPTH; k++) begin
        r_a_in[k] <= '0;
        r_b_in[k] <= '0;
      end
    end else if (enable) begin
      r_a_in[0] <= A;
      r_b_in[0] <= B;
      for (int k = 1; k < INPUT_REG_DEPTH; k++) begin
        r_a_in[k] <= r_a_in[k-1];
        r_b_in[k] <= r_b_in[k-1];
      end
    end
  end

  assign w_a_in = r_a_in[INPUT_REG_DEPTH-1];
  assign w_b_in = r_b_in[INPUT_REG_DEPTH-1];

  systolic_mac_tap #(
    .IN_WIDTH        (IN_WIDTH),
    .SKEW            (0),
    .MULT_PIPE_DEPTH (MULT_PIPE_DEPTH),
    .ADD_EN          (0),
    .SUM_W           (PSUM_W)
  ) u_tap0 (
    .clk     (clk),
    .reset   (reset),
    .en      (enable),
    .a       (w_a_in[IN_WIDTH-1:0]),
    .b       (w_b_in[IN_WIDTH-1:0]),
    .sum_in  ('0),
    .sum_out (w_psum[0])
  );

  generate
    for (genvar i = 1; i < N; i++) begin : g_tap
      systolic_mac_tap #(
        .IN_WIDTH        (IN_WIDTH),
        .SKEW            (i),
        .MULT_PIPE_DEPTH (MULT_PIPE_DEPTH),
        .ADD_EN          (1),
        .SUM_W           (PSUM_W)
      ) u_tap (
        .clk     (clk),
        .reset   (reset),
        .en      (enable),
        .a       (w_a_in[i*IN_WIDTH +: IN_WIDTH]),
        .b       (w_b_in[i*IN_WIDTH +: IN_WIDTH]),
        .sum_in  (w_psum[i-1]),
        .sum_out (w_psum[i])
      );
    end
  endgenerate

  assign w_tag_in.v     = inReady;
  assign w_tag_in.first = (ACCUMULATE != 0) ? inFirst : 1'b1;
  assign w_tag_in.last  = (ACCUMULATE != 0) ? inLast  : 1'b1;

  // Tag shift chain, aligned so its tail meets the final partial sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LAT_P; k++) r_tag[k] <= '0;
    end else if (enable) begin
      r_tag[0] <= w_tag_in;
      for (int k = 1; k < LAT_P; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign w_tag_end   = r_tag[LAT_P-1];
  assign w_sa        = sat_add(64'(r_acc), 64'(w_psum[N-1]), ACC_W, SATURATE != 0);
  assign w_unused_hi = ^w_sa.val[63:ACC_W];

  // Accumulator next state: restart on first or from IDLE, else add; emit on last.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_emit      = 1'b0;
    if (w_tag_end.v) begin
      if (w_tag_end.first || (r_state == ST_IDLE)) begin
        w_acc_nxt = ACC_W'(w_psum[N-1]);
        w_ovf_nxt = 1'b0;
      end else begin
        w_acc_nxt = w_sa.val[ACC_W-1:0];
        w_ovf_nxt = r_ovf | w_sa.ovf;
      end
      if (w_tag_end.last) begin
        w_emit      = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_ACCUM;
      end
    end
  end

  // Accumulator, FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_acc         <= '0;
      r_ovf         <= 1'b0;
      DP            <= '0;
      overflow      <= 1'b0;
      outReady      <= 1'b0;
      earlyOutReady <= 1'b0;
    end else if (enable) begin
      r_state       <= w_state_nxt;
      r_acc         <= w_acc_nxt;
      r_ovf         <= w_ovf_nxt;
      outReady      <= w_emit;
      earlyOutReady <= r_tag[LAT_P-2].v & r_tag[LAT_P-2].last;
      if (w_emit) begin
        DP       <= w_acc_nxt;
        overflow <= w_ovf_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dot_product_systolic_acc.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_dot_product_systolic_acc                                  |
// | Directed self-checking bench: N=4, IN_WIDTH=8, LAT_P=5.                |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_dot_product_systolic_acc;

  logic clk = 1'b0;
  logic reset, enable, inReady, inFirst, inLast;
  logic [31:0] A, B;
  logic early_m, out_m, ovf_m, early_s, out_s, ovf_s, early_w, out_w, ovf_w;
  logic signed [25:0] dp_m;
  logic signed [17:0] dp_s, dp_w;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dot_product_systolic_acc #(.N(4), .IN_WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
    .inFirst(inFirst), .inLast(inLast), .A(A), .B(B),
    .earlyOutReady(early_m), .outReady(out_m), .DP(dp_m), .overflow(ovf_m));

  dot_product_systolic_acc #(.N(4), .IN_WIDTH(8), .ACC_GUARD(0), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
    .inFirst(inFirst), .inLast(inLast), .A(A), .B(B),
    .earlyOutReady(early_s), .outReady(out_s), .DP(dp_s), .overflow(ovf_s));

  dot_product_systolic_acc #(.N(4), .IN_WIDTH(8), .ACC_GUARD(0), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .inReady(inReady),
    .inFirst(inFirst), .inLast(inLast), .A(A), .B(B),
    .earlyOutReady(early_w), .outReady(out_w), .DP(dp_w), .overflow(ovf_w));

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int a0, a1, a2, a3, b0, b1, b2, b3,
                          input logic f, input logic l);
    A = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    B = {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
    inReady = 1'b1;
    inFirst = f;
    inLast  = l;
  endtask

  task automatic set_uni(input int a, input int b, input logic f, input logic l);
    set_beat(a, a, a, a, b, b, b, b, f, l);
  endtask

  task automatic no_beat();
    inReady = 1'b0;
    inFirst = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic out_e, input logic early_e);
    check({tag, ".out"},   32'(out_m),   32'(out_e));
    check({tag, ".early"}, 32'(early_m), 32'(early_e));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; A = '0; B = '0;
    no_beat();
    repeat (3) tick();
    check_flags("rst", 1'b0, 1'b0);
    check("rst.dp", 32'(dp_m), 0);
    check("rst.ovf", 32'(ovf_m), 0);
    reset = 1'b1;
    tick();

    // Test 1: 1*5+2*6+3*7+4*8 = 70
    set_beat(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1);
    tick(); no_beat();
    repeat (3) tick();
    check_flags("t1.c4", 1'b0, 1'b0);
    tick();
    check_flags("t1.c5", 1'b0, 1'b1);
    tick();
    check_flags("t1.c6", 1'b1, 1'b0);
    check("t1.dp", 32'(dp_m), 70);
    check("t1.ovf", 32'(ovf_m), 0);
    tick();
    check_flags("t1.c7", 1'b0, 1'b0);
    check("t1.hold", 32'(dp_m), 70);

    // Test 2: 4*16384 = 65536, then 4*(-16256) = -65024 back to back
    set_uni(-128, -128, 1'b1, 1'b1);
    tick();
    set_uni(-128, 127, 1'b1, 1'b1);
    tick(); no_beat();
    repeat (4) tick();
    check("t2.out1", 32'(out_m), 1);
    check("t2.dp1", 32'(dp_m), 65536);
    tick();
    check("t2.out2", 32'(out_m), 1);
    check("t2.dp2", 32'(dp_m), -65024);
    tick();
    check("t2.out3", 32'(out_m), 0);

    // Test 3: three chunks of 4 -> single result 12
    set_uni(1, 1, 1'b1, 1'b0); tick();
    set_uni(1, 1, 1'b0, 1'b0); tick();
    set_uni(1, 1, 1'b0, 1'b1); tick();
    no_beat();
    check("t3.nopulse", 32'(out_m), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t3.nopulse", 32'(out_m), 0);
    end
    tick();
    check("t3.out", 32'(out_m), 1);
    check("t3.dp", 32'(dp_m), 12);
    tick();

    // Test 4: 65536+65536 = 131072 overflows an 18-bit accumulator
    set_uni(-128, -128, 1'b1, 1'b0); tick();
    set_uni(-128, -128, 1'b0, 1'b1); tick();
    no_beat();
    repeat (5) tick();
    check("t4.m.dp", 32'(dp_m), 131072);
    check("t4.m.ovf", 32'(ovf_m), 0);
    check("t4.s.out", 32'(out_s), 1);
    check("t4.s.dp", 32'(dp_s), 131071);
    check("t4.s.ovf", 32'(ovf_s), 1);
    check("t4.w.out", 32'(out_w), 1);
    check("t4.w.dp", 32'(dp_w), -131072);
    check("t4.w.ovf", 32'(ovf_w), 1);
    tick();

    // Test 5: enable low for 3 cycles at beat+2 -> result at beat+9
    set_beat(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1);
    tick(); no_beat();
    tick();
    enable = 1'b0;
    repeat (3) begin
      tick();
      check_flags("t5.frozen", 1'b0, 1'b0);
      check("t5.frozen.dp", 32'(dp_m), 131072);
    end
    enable = 1'b1;
    repeat (3) tick();
    check_flags("t5.c8", 1'b0, 1'b1);
    tick();
    check_flags("t5.c9", 1'b1, 1'b0);
    check("t5.dp", 32'(dp_m), 70);
    check("t5.s.dp", 32'(dp_s), 70);
    check("t5.s.ovf", 32'(ovf_s), 0);
    enable = 1'b0;
    repeat (2) tick();
    check("t5.heldpulse", 32'(out_m), 1);
    check("t5.helddp", 32'(dp_m), 70);
    enable = 1'b1;
    tick();
    check("t5.pulseend", 32'(out_m), 0);

    // Test 6: reset at beat+3 discards the beat
    set_beat(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1);
    tick(); no_beat();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_flags("t6.rst", 1'b0, 1'b0);
    check("t6.rst.dp", 32'(dp_m), 0);
    check("t6.rst.sdp", 32'(dp_s), 0);
    check("t6.rst.ovf", 32'(ovf_s), 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t6.nopulse", 32'(out_m), 0);
    end
    // Repeat with last but no first: treated as a fresh accumulation
    set_beat(1, 2, 3, 4, 5, 6, 7, 8, 1'b0, 1'b1);
    tick(); no_beat();
    repeat (5) tick();
    check("t6.out", 32'(out_m), 1);
    check("t6.dp", 32'(dp_m), 70);
    tick();

    // Test 7: a new first while accumulating drops the open sum
    set_uni(1, 1, 1'b1, 1'b0); tick();
    set_beat(1, 2, 3, 4, 5, 6, 7, 8, 1'b1, 1'b1); tick();
    no_beat();
    repeat (3) tick();
    check_flags("t7.c4", 1'b0, 1'b0);
    tick();
    check_flags("t7.c5", 1'b0, 1'b1);
    tick();
    check_flags("t7.c6", 1'b1, 1'b0);
    check("t7.dp", 32'(dp_m), 70);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
